// File: rtl/pump3_seq_pkg.sv
// Shared types and constants for the 3-valve peristaltic pump sequencer.
// Optional hold/stall input is enabled by defining PUMP3_SEQ_STALL_EN.
package pump3_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SEAL
   } state_t;

   localparam int NUM_PHASES = 6;
   localparam logic [2:0] SEALED = 3'b111;
   localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

   // Index 0..5 is phase P0..P5; bit 0 = pump1, 1 = pressurized.
   localparam logic [2:0] PUMP3_PATTERN [NUM_PHASES] = '{
      3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
   };

   function automatic logic [2:0] pattern_of(input logic [2:0] idx);
      logic [2:0] pat;
      case (idx)
         3'd0:    pat = PUMP3_PATTERN[0];
         3'd1:    pat = PUMP3_PATTERN[1];
         3'd2:    pat = PUMP3_PATTERN[2];
         3'd3:    pat = PUMP3_PATTERN[3];
         3'd4:    pat = PUMP3_PATTERN[4];
         3'd5:    pat = PUMP3_PATTERN[5];
         default: pat = SEALED;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/pump3_seq_ctrl_dwell_timer.sv
// Loadable down-counter timing one phase (RUN) or the seal interval (SEAL).
// expire marks the last clock of the loaded interval; load has priority.
module pump3_dwell_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire,
   output logic [W-1:0] count_next
);

   logic [W-1:0] count;

   always_comb begin
      count_next = count;
      if (load) begin
         count_next = load_val;
      end else if (en && (count != '0)) begin
         count_next = count - W'(1);
      end
   end

   assign expire = en && (count == W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/pump3_seq_ctrl.sv
// Six-phase peristaltic sequencer for one 3-valve pump, with seal-on-finish/abort.
// Define PUMP3_SEQ_STALL_EN to add the 'hold' input that freezes RUN/SEAL timing.
module pump3_seq_ctrl
   import pump3_seq_pkg::*;
#(
   parameter int DWELL_W = 16,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dir,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [CNT_W-1:0]   n_cycles,
   input  logic               abort,
`ifdef PUMP3_SEQ_STALL_EN
   input  logic               hold,
`endif
   output logic [2:0]         valve_ctrl,
   output logic [2:0]         phase,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   cycles_done
);

   state_t             state_q, state_n;
   logic [2:0]         phase_q, phase_n;
   logic               dir_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [CNT_W-1:0]   ncyc_q;
   logic [CNT_W-1:0]   cyc_n, cyc_inc;
   logic [DWELL_W-1:0] dwell_eff, load_val, count_next;
   logic               accept, stall, timer_en, load, expire, last_phase;
   logic [2:0]         valve_n, phase_out_n;
   logic               busy_n, done_n;

`ifdef PUMP3_SEQ_STALL_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign accept     = (state_q == IDLE) && start;
   assign timer_en   = (state_q != IDLE) && !stall;
   assign last_phase = dir_q ? (phase_q == 3'd0) : (phase_q == LAST_PHASE);
   assign cyc_inc    = cycles_done + CNT_W'(1);

   pump3_dwell_timer #(.W(DWELL_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_val   (load_val),
      .en         (timer_en),
      .expire     (expire),
      .count_next (count_next)
   );

   always_comb begin
      state_n  = state_q;
      phase_n  = phase_q;
      cyc_n    = cycles_done;
      load     = 1'b0;
      load_val = dwell_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n  = RUN;
               load     = 1'b1;
               load_val = dwell_eff;
               phase_n  = dir ? LAST_PHASE : 3'd0;
               cyc_n    = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = SEAL;
               load    = 1'b1;
            end else if (expire) begin
               load = 1'b1;
               if (last_phase) begin
                  cyc_n = cyc_inc;
                  if ((ncyc_q != '0) && (cyc_inc == ncyc_q)) begin
                     state_n = SEAL;
                  end else begin
                     phase_n = dir_q ? LAST_PHASE : 3'd0;
                  end
               end else begin
                  phase_n = dir_q ? (phase_q - 3'd1) : (phase_q + 3'd1);
               end
            end
         end
         SEAL: begin
            if (expire) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so they line up with state.
   always_comb begin
      busy_n      = (state_n != IDLE);
      valve_n     = (state_n == RUN) ? pattern_of(phase_n) : SEALED;
      phase_out_n = (state_n == RUN) ? phase_n : 3'd0;
      done_n      = (state_n == SEAL) && (count_next == DWELL_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= 3'd0;
         dir_q       <= 1'b0;
         dwell_q     <= DWELL_W'(1);
         ncyc_q      <= '0;
         cycles_done <= '0;
         valve_ctrl  <= SEALED;
         phase       <= 3'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_n;
         phase_q     <= phase_n;
         cycles_done <= cyc_n;
         valve_ctrl  <= valve_n;
         phase       <= phase_out_n;
         busy        <= busy_n;
         done        <= done_n;
         if (accept) begin
            dir_q   <= dir;
            dwell_q <= dwell_eff;
            ncyc_q  <= n_cycles;
         end
      end
   end

endmodule

// File: tb/tb_pump3_seq_ctrl.sv
// Directed self-checking bench for pump3_seq_ctrl (hold test when PUMP3_SEQ_STALL_EN is defined).
module tb_pump3_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] dwell = 16'd0;
   logic [15:0] n_cycles = 16'd0;
`ifdef PUMP3_SEQ_STALL_EN
   logic        hold = 1'b0;
`endif
   logic [2:0]  valve_ctrl;
   logic [2:0]  phase;
   logic        busy;
   logic        done;
   logic [15:0] cycles_done;

   int vectors = 0;
   int miscompares = 0;

   logic [2:0] pat [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   always #5 clk = ~clk;

   pump3_seq_ctrl #(.DWELL_W(16), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dir         (dir),
      .dwell       (dwell),
      .n_cycles    (n_cycles),
      .abort       (abort),
`ifdef PUMP3_SEQ_STALL_EN
      .hold        (hold),
`endif
      .valve_ctrl  (valve_ctrl),
      .phase       (phase),
      .busy        (busy),
      .done        (done),
      .cycles_done (cycles_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic [2:0] v, input logic [2:0] ph,
                             input logic b, input logic dn, input logic [15:0] cy);
      checkOutput({tag, ".valve"}, 32'(valve_ctrl), 32'(v));
      checkOutput({tag, ".phase"}, 32'(phase), 32'(ph));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
      checkOutput({tag, ".done"}, 32'(done), 32'(dn));
      checkOutput({tag, ".cycles"}, 32'(cycles_done), 32'(cy));
   endtask

   task automatic applyStimulus(input logic d, input logic [15:0] dw, input logic [15:0] n);
      dir      = d;
      dwell    = dw;
      n_cycles = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   initial begin
      #12;
      checkState("reset", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkState("idle0", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);

      // Forward, dwell 3, two cycles; a second start mid-run must be ignored.
      applyStimulus(1'b0, 16'd3, 16'd2);
      for (int k = 0; k < 36; k++) begin
         checkState($sformatf("fwd%0d", k), pat[(k / 3) % 6], 3'((k / 3) % 6), 1'b1, 1'b0, 16'(k / 18));
         if (k == 4) begin
            start = 1'b1;
            dwell = 16'd7;
         end
         if (k == 10) start = 1'b0;
         tick();
      end
      for (int k = 36; k < 39; k++) begin
         checkState($sformatf("fwd_seal%0d", k), 3'b111, 3'd0, 1'b1, (k == 38), 16'd2);
         tick();
      end
      checkState("fwd_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd2);

      // Reverse, dwell 1, one cycle.
      applyStimulus(1'b1, 16'd1, 16'd1);
      for (int k = 0; k < 6; k++) begin
         checkState($sformatf("rev%0d", k), pat[5 - k], 3'(5 - k), 1'b1, 1'b0, 16'd0);
         tick();
      end
      checkState("rev_seal", 3'b111, 3'd0, 1'b1, 1'b1, 16'd1);
      tick();
      checkState("rev_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd1);

      // Dwell 0 behaves as dwell 1.
      applyStimulus(1'b0, 16'd0, 16'd1);
      for (int k = 0; k < 6; k++) begin
         checkState($sformatf("dw0_%0d", k), pat[k], 3'(k), 1'b1, 1'b0, 16'd0);
         tick();
      end
      checkState("dw0_seal", 3'b111, 3'd0, 1'b1, 1'b1, 16'd1);
      tick();
      checkState("dw0_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd1);

      // Start and abort together in IDLE: start wins.
      abort = 1'b1;
      applyStimulus(1'b0, 16'd1, 16'd3);
      abort = 1'b0;
      checkState("sa0", 3'b101, 3'd0, 1'b1, 1'b0, 16'd0);
      tick();
      checkState("sa1", 3'b100, 3'd1, 1'b1, 1'b0, 16'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkState("sa_seal", 3'b111, 3'd0, 1'b1, 1'b1, 16'd0);
      tick();
      checkState("sa_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkState("abort_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);

      // Continuous run, dwell 2, abort during P2 of the first cycle.
      applyStimulus(1'b0, 16'd2, 16'd0);
      for (int k = 0; k < 5; k++) begin
         checkState($sformatf("ab%0d", k), pat[k / 2], 3'(k / 2), 1'b1, 1'b0, 16'd0);
         if (k == 4) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      checkState("ab_seal0", 3'b111, 3'd0, 1'b1, 1'b0, 16'd0);
      tick();
      checkState("ab_seal1", 3'b111, 3'd0, 1'b1, 1'b1, 16'd0);
      tick();
      checkState("ab_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);

`ifdef PUMP3_SEQ_STALL_EN
      // Hold for 5 clocks inside P0 stretches it from 3 to 8 clocks.
      applyStimulus(1'b0, 16'd3, 16'd1);
      checkState("hold0", 3'b101, 3'd0, 1'b1, 1'b0, 16'd0);
      tick();
      checkState("hold1", 3'b101, 3'd0, 1'b1, 1'b0, 16'd0);
      hold = 1'b1;
      for (int k = 2; k < 7; k++) begin
         tick();
         checkState($sformatf("hold%0d", k), 3'b101, 3'd0, 1'b1, 1'b0, 16'd0);
      end
      hold = 1'b0;
      tick();
      checkState("hold7", 3'b101, 3'd0, 1'b1, 1'b0, 16'd0);
      tick();
      checkState("hold8", 3'b100, 3'd1, 1'b1, 1'b0, 16'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      tick();
      checkState("hold_seal", 3'b111, 3'd0, 1'b1, 1'b1, 16'd0);
      tick();
      checkState("hold_idle", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);
`endif

      // Continuous run wraps through cycles; async reset mid-run clears everything.
      applyStimulus(1'b0, 16'd1, 16'd0);
      for (int k = 0; k < 14; k++) begin
         checkState($sformatf("cont%0d", k), pat[k % 6], 3'(k % 6), 1'b1, 1'b0, 16'(k / 6));
         if (k < 13) tick();
      end
      #3;
      rst_n = 1'b0;
      #1;
      checkState("async_rst", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkState("post_rst", 3'b111, 3'd0, 1'b0, 1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
